// File: rtl/game_io_pkg.sv
// Shared constants for the game I/O blocks: FSM encoding, debounce default
// and the position of the optional hit-count field.
package game_io_pkg;

   localparam int DEBOUNCE_DEFAULT = 50000;
   localparam int DB_CNT_W         = 20;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_HIT   = 2'd2;

   localparam int HIT_CNT_LSB = 8;
   localparam int HIT_CNT_W   = 8;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer plus counter debouncer for one asynchronous input;
// emits the stable level and a one-cycle pulse on its rising transitions.
module input_debounce
   import game_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic ctrl_reset_n,
   input  logic raw,
   output logic stable,
   output logic rise
);

   // Toggle on the cycle the count would reach DEBOUNCE_CYCLES, so the
   // stable level moves DEBOUNCE_CYCLES+2 edges after the raw change.
   localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                sync1, sync2;
   logic [DB_CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt    <= '0;
            stable <= ~stable;
            rise   <= ~stable;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/target_hit_detect.sv
// Button/target-sensor front end with one IDLE/ARMED/HIT machine per target.
// Define TARGET_HIT_COUNT_EN to add a saturating hit count in bits 15:8.
module target_hit_detect
   import game_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic        clock,
   input  logic        ctrl_reset_n,
   input  logic        btn_raw,
   input  logic        t1_sensor_raw,
   input  logic        t2_sensor_raw,
   input  logic [31:0] t1active_read,
   input  logic [31:0] t2active_read,
   output logic [31:0] bp_write,
   output logic [31:0] t1hit_write,
   output logic [31:0] t2hit_write
);

   logic             btn_stable;
   logic             btn_rise_unused;
   logic [1:0]       sensor_raw;
   logic [1:0]       sensor_rise;
   logic [1:0]       sensor_level_unused;
   logic [1:0]       active;
   logic [1:0][31:0] hit_word;

   assign sensor_raw = {t2_sensor_raw, t1_sensor_raw};
   assign active     = {|t2active_read, |t1active_read};

   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .raw          (btn_raw),
      .stable       (btn_stable),
      .rise         (btn_rise_unused)
   );

   for (genvar t = 0; t < 2; t++) begin : g_tgt
      logic [1:0] state;

      input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock        (clock),
         .ctrl_reset_n (ctrl_reset_n),
         .raw          (sensor_raw[t]),
         .stable       (sensor_level_unused[t]),
         .rise         (sensor_rise[t])
      );

      // Deactivation is tested before the press so a drop wins a tie.
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
         if (!ctrl_reset_n) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE:  if (active[t]) state <= ST_ARMED;
               ST_ARMED: if (!active[t])          state <= ST_IDLE;
                         else if (sensor_rise[t]) state <= ST_HIT;
               ST_HIT:   if (!active[t]) state <= ST_IDLE;
               default:  state <= ST_IDLE;
            endcase
         end
      end

`ifdef TARGET_HIT_COUNT_EN
      logic [HIT_CNT_W-1:0] hit_cnt;

      always_ff @(posedge clock or negedge ctrl_reset_n) begin
         if (!ctrl_reset_n) begin
            hit_cnt <= '0;
         end else if (state == ST_ARMED && active[t] && sensor_rise[t] &&
                      hit_cnt != '1) begin
            hit_cnt <= hit_cnt + 1'b1;
         end
      end

      assign hit_word[t] = (32'(hit_cnt) << HIT_CNT_LSB) | 32'(state == ST_HIT);
`else
      assign hit_word[t] = {31'd0, state == ST_HIT};
`endif
   end

   assign bp_write    = {31'd0, btn_stable};
   assign t1hit_write = hit_word[0];
   assign t2hit_write = hit_word[1];

endmodule

// File: tb/tb_target_hit_detect.sv
// Directed bench for target_hit_detect with DEBOUNCE_CYCLES=4; builds with or
// without TARGET_HIT_COUNT_EN.
module tb_target_hit_detect;

`ifdef TARGET_HIT_COUNT_EN
   localparam bit COUNT_ON = 1'b1;
`else
   localparam bit COUNT_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        ctrl_reset_n = 1'b0;
   logic        btn_raw = 1'b0, t1_sensor_raw = 1'b0, t2_sensor_raw = 1'b0;
   logic [31:0] t1active_read = '0, t2active_read = '0;
   logic [31:0] bp_write, t1hit_write, t2hit_write;

   int n_cmp = 0;
   int n_bad = 0;
   int bad_cycles = 0;

   typedef struct {
      int btn, s1, s2, a1, a2, n, eb, e1, e2, c1, c2;
   } vec_t;

   vec_t tv [23];

   target_hit_detect #(.DEBOUNCE_CYCLES(4)) dut (
      .clock         (clock),
      .ctrl_reset_n  (ctrl_reset_n),
      .btn_raw       (btn_raw),
      .t1_sensor_raw (t1_sensor_raw),
      .t2_sensor_raw (t2_sensor_raw),
      .t1active_read (t1active_read),
      .t2active_read (t2active_read),
      .bp_write      (bp_write),
      .t1hit_write   (t1hit_write),
      .t2hit_write   (t2hit_write)
   );

   always #5 clock = ~clock;

   // Fields outside the flag and (when enabled) the count must never move.
   always @(negedge clock) begin
      if (bp_write[31:1] != 31'd0 || t1hit_write[31:16] != 16'd0 ||
          t2hit_write[31:16] != 16'd0 || t1hit_write[7:1] != 7'd0 ||
          t2hit_write[7:1] != 7'd0 ||
          (!COUNT_ON && (t1hit_write[15:8] != 8'd0 || t2hit_write[15:8] != 8'd0)))
         bad_cycles++;
   end

   function automatic logic [31:0] hw(int flag, int c);
      logic [31:0] w;
      w = 32'(flag & 1);
      if (COUNT_ON) w = w | (32'(c & 255) << 8);
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      //        btn s1 s2 a1 a2  n  eb e1 e2 c1 c2
      tv = '{
         '{0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0},   // idle after reset
         '{1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0},   // button: not yet at 5 edges
         '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0},   // accepted at edge 6
         '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0},   // held 10 total
         '{0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0},  // released
         '{1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0},   // 3-cycle glitch
         '{0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0},   // glitch discarded
         '{0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0},   // arm t1
         '{0, 1, 0, 1, 0, 6, 0, 0, 0, 0, 0},   // sensor up, 6 edges
         '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0},   // hit at edge 7
         '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0},   // held 8
         '{0, 0, 0, 1, 0, 8, 0, 1, 0, 1, 0},   // release: stays HIT
         '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0},   // deactivate -> IDLE next cycle
         '{0, 0, 1, 0, 0, 10, 0, 0, 0, 1, 0},  // t2 sensor high while idle
         '{0, 0, 1, 0, 5, 3, 0, 0, 0, 1, 0},   // arm with sensor already high
         '{0, 0, 0, 0, 5, 10, 0, 0, 0, 1, 0},  // release
         '{0, 0, 1, 0, 5, 7, 0, 0, 1, 1, 1},   // re-press -> hit
         '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1},   // deactivate
         '{0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 1},  // settle
         '{0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 1},   // arm both
         '{0, 1, 1, 1, 1, 6, 0, 0, 0, 1, 1},   // both sensors up
         '{0, 1, 1, 1, 1, 1, 0, 1, 1, 2, 2},   // both hit same cycle
         '{0, 0, 0, 0, 0, 10, 0, 0, 0, 2, 2}   // clear
      };

      #3;
      check("reset_bp", bp_write, 32'd0);
      check("reset_t1", t1hit_write, 32'd0);
      check("reset_t2", t2hit_write, 32'd0);
      @(negedge clock);
      ctrl_reset_n = 1'b1;

      foreach (tv[i]) begin
         btn_raw       = tv[i].btn[0];
         t1_sensor_raw = tv[i].s1[0];
         t2_sensor_raw = tv[i].s2[0];
         t1active_read = 32'(tv[i].a1);
         t2active_read = 32'(tv[i].a2);
         wait_edges(tv[i].n);
         check($sformatf("vec%0d_bp", i), bp_write, 32'(tv[i].eb));
         check($sformatf("vec%0d_t1", i), t1hit_write, hw(tv[i].e1, tv[i].c1));
         check($sformatf("vec%0d_t2", i), t2hit_write, hw(tv[i].e2, tv[i].c2));
      end

      // Deactivation in the same cycle as the press pulse.
      t1active_read = 32'd1;
      wait_edges(2);
      t1_sensor_raw = 1'b1;
      repeat (6) @(posedge clock);
      @(negedge clock);
      t1active_read = 32'd0;
      wait_edges(1);
      check("collide_edge7", t1hit_write, hw(0, 2));
      wait_edges(3);
      check("collide_later", t1hit_write, hw(0, 2));
      t1active_read = 32'd1;
      wait_edges(10);
      check("collide_rearm_no_edge", t1hit_write, hw(0, 2));
      t1active_read = 32'd0;
      t1_sensor_raw = 1'b0;
      wait_edges(10);

      // Asynchronous reset while in HIT.
      btn_raw = 1'b1;
      t1active_read = 32'd1;
      wait_edges(2);
      t1_sensor_raw = 1'b1;
      wait_edges(7);
      check("prereset_t1", t1hit_write, hw(1, 3));
      check("prereset_bp", bp_write, 32'd1);
      #2 ctrl_reset_n = 1'b0;
      #1;
      check("async_reset_bp", bp_write, 32'd0);
      check("async_reset_t1", t1hit_write, 32'd0);
      check("async_reset_t2", t2hit_write, 32'd0);
      btn_raw = 1'b0;
      t1_sensor_raw = 1'b0;
      t1active_read = 32'd0;
      @(negedge clock);
      ctrl_reset_n = 1'b1;
      wait_edges(3);
      check("post_reset_bp", bp_write, 32'd0);
      check("post_reset_t1", t1hit_write, 32'd0);
      check("post_reset_t2", t2hit_write, 32'd0);

      // 300 arm/hit/deactivate rounds on target 1.
      for (int k = 1; k <= 300; k++) begin
         t1active_read = 32'd1;
         wait_edges(2);
         t1_sensor_raw = 1'b1;
         wait_edges(8);
         if (k == 1) check("count_round1_flag", t1hit_write, hw(1, 1));
         t1active_read = 32'd0;
         t1_sensor_raw = 1'b0;
         wait_edges(8);
         if (k == 100) check("count_100", t1hit_write, hw(0, 100));
      end
      check("count_sat_255", t1hit_write, hw(0, 255));
      check("count_t2_untouched", t2hit_write, 32'd0);

      check("upper_bits_zero", 32'(bad_cycles), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/target_hit_detect.md
TARGET_HIT_DETECT -- requirements
Module: target_hit_detect

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable synchronized samples required to accept a level change (legal range 1 to 2^20-1).
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port ctrl_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port btn_raw, input, 1 bit: asynchronous player button.
REQ-005 SHALL have port t1_sensor_raw, input, 1 bit: asynchronous target-1 hit sensor.
REQ-006 SHALL have port t2_sensor_raw, input, 1 bit: asynchronous target-2 hit sensor.
REQ-007 SHALL have port t1active_read, input, 32 bits: target-1 active word from the register file; nonzero means active.
REQ-008 SHALL have port t2active_read, input, 32 bits: target-2 active word, same encoding as t1active_read.
REQ-009 SHALL have port bp_write, output, 32 bits: debounced button level in bit 0; bits 31:1 are zero.
REQ-010 SHALL have port t1hit_write, output, 32 bits: target-1 hit flag in bit 0, plus the optional count field defined in REQ-026.
REQ-011 SHALL have port t2hit_write, output, 32 bits: target-2 hit flag, same layout as t1hit_write.

Function
REQ-012 SHALL pass each raw input through a two-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized input with its own counter:
- the counter clears whenever the synchronized input equals the stable level;
- otherwise the counter increments;
- when the counter reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
REQ-014 SHALL produce a one-cycle press pulse on each 0-to-1 transition of a stable level.
REQ-015 SHALL update the stable level exactly DEBOUNCE_CYCLES+2 cycles after a clean raw level change.
REQ-016 SHALL discard any glitch shorter than DEBOUNCE_CYCLES cycles, leaving the stable level unchanged.
REQ-017 SHALL drive bp_write[0] from the registered stable button level.
REQ-018 SHALL run one independent state machine per target with states IDLE, ARMED and HIT.
REQ-019 SHALL use these state transitions:
- IDLE to ARMED when the matching active word is nonzero;
- ARMED to HIT on a press pulse from the target's sensor;
- ARMED to IDLE when the active word becomes zero;
- HIT to IDLE when the active word becomes zero.
REQ-020 SHALL drive the hit flag in bit 0 high exactly while the state is HIT, one cycle after the press pulse.
REQ-021 SHALL ignore press pulses while IDLE.
REQ-022 SHALL NOT generate a hit from a sensor level that is already high when the machine arms; only a new rising edge counts.
REQ-023 SHALL give deactivation priority when the active word drops in the same cycle as a press pulse: the state goes to IDLE and no hit is recorded.
REQ-024 SHALL keep the two targets fully independent, so that simultaneous hits on both targets set both flags in the same cycle.

Reset
REQ-025 SHALL, while ctrl_reset_n is low, immediately force the following state regardless of clock:
- synchronizers, stable levels, counters and press pulses to 0;
- both state machines to IDLE;
- all outputs to 32'd0.

Configuration
REQ-026 SHALL implement optional hit counting under macro TARGET_HIT_COUNT_EN:
- when defined, each target keeps an 8-bit saturating count of ARMED-to-HIT transitions, reported in hit-output bits 15:8;
- the count holds at 255 once reached and clears only on reset;
- when undefined, bits 31:1 are constant zero and no count logic is synthesized.

Structure
REQ-027 SHALL place the state encoding (IDLE=2'd0, ARMED=2'd1, HIT=2'd2), the default debounce value and the count field position and width in shared package game_io_pkg.
REQ-028 SHALL implement the synchronizer and debouncer as sub-module input_debounce, instantiated three times, with output ports stable and rise.

Verification
REQ-029 SHALL, with DEBOUNCE_CYCLES=4 for all scenarios, cover these directed cases:
- Button: btn_raw high for 10 cycles -> bp_write=32'd1 exactly 6 cycles after the rise; a 3-cycle pulse -> bp_write stays 0.
- Basic hit: t1active_read=1, then t1_sensor_raw rises and is held 8 cycles -> t1hit_write=1 from cycle 7 after the sensor rise; t1active_read=0 -> t1hit_write=0 on the next cycle.
- Pre-armed sensor: t2_sensor_raw held high before t2active_read=5 -> t2hit_write stays 0; releasing and re-pressing the sensor -> t2hit_write=1.
- Collision and simultaneity: deactivation in the same cycle as a press pulse -> no hit recorded; both sensors rising together while both targets are armed -> both flags set in the same cycle.
- Reset mid-operation: ctrl_reset_n low while in HIT -> all outputs 0 asynchronously, before the next clock edge; after release, states are IDLE.
- Counting, with TARGET_HIT_COUNT_EN defined: 300 arm/hit/deactivate cycles on target 1 -> t1hit_write[15:8]=255; undefined -> bits 31:1 remain 0 throughout.
